// File: rtl/trackball_gen.sv
// Trackball/spinner emulator: per-axis saturating movement accumulators drained
// one step per prescaler tick, emitted as dir/clock pairs or Gray quadrature.
module trackball_gen #(
    parameter int AXES     = 2,
    parameter int ACC_W    = 12,
    parameter int STEP_DIV = 1,
    parameter int MODE     = 0
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic [9*AXES-1:0]    delta_i,
    input  logic                 delta_stb,
    input  logic [AXES-1:0]      flip_i,
    input  logic [1:0]           sens_i,
    input  logic                 clr_i,
    output logic [AXES-1:0]      out_a,
    output logic [AXES-1:0]      out_b,
    output logic [AXES-1:0]      moving_o
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic signed [ACC_W+1:0] L_ONE = (ACC_W+2)'(1);
    localparam logic signed [ACC_W+1:0] L_MAX = (ACC_W+2)'(2**(ACC_W-1) - 1);
    localparam logic signed [ACC_W+1:0] L_MIN = -L_MAX - L_ONE;

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_W'(STEP_DIV - 1));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!clr_i) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
        end
    end

    for (genvar a = 0; a < AXES; a++) begin : g_axis
        logic signed [ACC_W-1:0] r_acc;
        logic [1:0]              r_phase;
        logic                    r_out_a;
        logic                    r_out_b;
        logic                    r_moving;
        logic signed [ACC_W:0]   w_ext;
        logic signed [ACC_W:0]   w_scaled;
        logic signed [ACC_W+1:0] w_sum;
        logic signed [ACC_W-1:0] w_acc_next;
        logic                    w_step_en;
        logic                    w_dir;
        logic [1:0]              w_phase_next;

        always_comb begin
            w_ext = (ACC_W+1)'(signed'(delta_i[9*a +: 9]));
            w_ext = w_ext <<< sens_i;
            w_scaled = '0;
            if (delta_stb) begin
                w_scaled = flip_i[a] ? -w_ext : w_ext;
            end

            // Sign bit alone gives direction because a step only happens when acc != 0.
            w_step_en = w_tick && !clr_i && (r_acc != '0);
            w_dir     = ~r_acc[ACC_W-1];

            w_sum = (ACC_W+2)'(r_acc) + (ACC_W+2)'(w_scaled);
            if (w_step_en) begin
                w_sum = w_dir ? (w_sum - L_ONE) : (w_sum + L_ONE);
            end

            if (w_sum > L_MAX) begin
                w_acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end else if (w_sum < L_MIN) begin
                w_acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                w_acc_next = w_sum[ACC_W-1:0];
            end
            if (clr_i) begin
                w_acc_next = '0;
            end

            w_phase_next = r_phase;
            if (w_step_en) begin
                w_phase_next = w_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_acc    <= '0;
                r_phase  <= '0;
                r_out_a  <= 1'b0;
                r_out_b  <= 1'b0;
                r_moving <= 1'b0;
            end else begin
                r_acc    <= w_acc_next;
                r_moving <= (w_acc_next != '0);
                if (w_step_en) begin
                    r_phase <= w_phase_next;
                    if (MODE == 0) begin
                        r_out_a <= w_dir;
                        r_out_b <= ~r_out_b;
                    end else begin
                        r_out_a <= w_phase_next[1];
                        r_out_b <= w_phase_next[1] ^ w_phase_next[0];
                    end
                end
            end
        end

        assign out_a[a]    = r_out_a;
        assign out_b[a]    = r_out_b;
        assign moving_o[a] = r_moving;
    end

endmodule

// File: tb/tb_trackball_gen.sv
// Directed bench: dut0 is MODE0 with STEP_DIV=1, dut1 is MODE1 with STEP_DIV=4.
module tb_trackball_gen;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [17:0] delta_i;
    logic        delta_stb;
    logic [1:0]  flip_i;
    logic [1:0]  sens_i;
    logic        clr_i;
    logic [1:0]  a0, b0, m0;
    logic [1:0]  a1, b1, m1;

    int checks   = 0;
    int failures = 0;
    int bad;

    always #5 clk_sys = ~clk_sys;

    trackball_gen #(.AXES(2), .ACC_W(12), .STEP_DIV(1), .MODE(0)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .delta_i(delta_i), .delta_stb(delta_stb),
        .flip_i(flip_i), .sens_i(sens_i), .clr_i(clr_i),
        .out_a(a0), .out_b(b0), .moving_o(m0)
    );

    trackball_gen #(.AXES(2), .ACC_W(12), .STEP_DIV(4), .MODE(1)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .delta_i(delta_i), .delta_stb(delta_stb),
        .flip_i(flip_i), .sens_i(sens_i), .clr_i(clr_i),
        .out_a(a1), .out_b(b1), .moving_o(m1)
    );

    function automatic logic [17:0] pack(input logic signed [8:0] x, input logic signed [8:0] y);
        return {y, x};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; delta_i = '0; delta_stb = 1'b0;
        flip_i = '0; sens_i = '0; clr_i = 1'b0;
        cyc(1);

        // reset state
        do_reset();
        chk("rst_a0", {30'd0, a0}, 32'd0);
        chk("rst_b0", {30'd0, b0}, 32'd0);
        chk("rst_m0", {30'd0, m0}, 32'd0);
        chk("rst_ab1", {28'd0, a1, b1}, 32'd0);
        chk("rst_m1", {30'd0, m1}, 32'd0);

        // +3 on X, MODE0 every-cycle tick: three toggles, axis 1 idle
        delta_i = pack(9'sd3, 9'sd0); delta_stb = 1'b1;
        cyc(1);
        delta_stb = 1'b0;
        chk("p3_e1_b", {30'd0, b0}, 32'd0);
        chk("p3_e1_m", {30'd0, m0}, 32'd1);
        cyc(1);
        chk("p3_e2_a", {30'd0, a0}, 32'd1);
        chk("p3_e2_b", {30'd0, b0}, 32'd1);
        cyc(1);
        chk("p3_e3_b", {30'd0, b0}, 32'd0);
        chk("p3_e3_m", {30'd0, m0}, 32'd1);
        cyc(1);
        chk("p3_e4_b", {30'd0, b0}, 32'd1);
        chk("p3_e4_m", {30'd0, m0}, 32'd0);
        cyc(1);
        chk("p3_e5_ab", {28'd0, a0, b0}, {28'd0, 2'b01, 2'b01});
        chk("p3_e5_m", {30'd0, m0}, 32'd0);

        // MODE1, STEP_DIV=4: -2 on X gives Gray 10 then 11, four cycles apart
        do_reset();
        delta_i = pack(-9'sd2, 9'sd0); delta_stb = 1'b1;
        cyc(1);
        delta_stb = 1'b0;
        cyc(2);
        chk("q_e3_ab", {28'd0, a1, b1}, 32'd0);
        chk("q_e3_m", {30'd0, m1}, 32'd1);
        cyc(1);
        chk("q_e4_ab", {28'd0, a1, b1}, {28'd0, 2'b01, 2'b00});
        cyc(3);
        chk("q_e7_ab", {28'd0, a1, b1}, {28'd0, 2'b01, 2'b00});
        chk("q_e7_m", {30'd0, m1}, 32'd1);
        cyc(1);
        chk("q_e8_ab", {28'd0, a1, b1}, {28'd0, 2'b01, 2'b01});
        chk("q_e8_m", {30'd0, m1}, 32'd0);
        cyc(4);
        chk("q_e12_ab", {28'd0, a1, b1}, {28'd0, 2'b01, 2'b01});

        // saturation: 3 x (+255 << 3) clamps X at 2047; Y gets a single +16
        do_reset();
        sens_i = 2'd3; delta_stb = 1'b1;
        delta_i = pack(9'sd255, 9'sd2);
        cyc(1);
        delta_i = pack(9'sd255, 9'sd0);
        cyc(2);
        delta_stb = 1'b0; sens_i = 2'd0; delta_i = '0;
        chk("sat_e3_m", {30'd0, m0}, 32'd3);
        bad = 0;
        for (int k = 4; k <= 2049; k++) begin
            cyc(1);
            if (a0[0] !== 1'b1 || m0[0] !== 1'b1) bad++;
            if (k == 16) chk("sat_y_e16_m", {30'd0, m0}, 32'd3);
            if (k == 17) chk("sat_y_e17_m", {30'd0, m0}, 32'd1);
        end
        chk("sat_dir_hold", bad, 32'd0);
        cyc(1);
        chk("sat_e2050_m", {30'd0, m0}, 32'd0);
        chk("sat_e2050_a", {30'd0, a0}, 32'd3);
        chk("sat_e2050_b", {30'd0, b0}, 32'd1);

        // flip with +5 arriving on the tick that drains acc=+1
        do_reset();
        delta_i = pack(9'sd1, 9'sd0); delta_stb = 1'b1;
        cyc(1);
        delta_i = pack(9'sd5, 9'sd0); flip_i = 2'b01;
        cyc(1);
        delta_stb = 1'b0; flip_i = 2'b00;
        chk("flip_e2_ab", {28'd0, a0, b0}, {28'd0, 2'b01, 2'b01});
        chk("flip_e2_m", {30'd0, m0}, 32'd1);
        cyc(1);
        chk("flip_e3_ab", {28'd0, a0, b0}, 32'd0);
        cyc(3);
        chk("flip_e6_b", {30'd0, b0}, 32'd1);
        chk("flip_e6_m", {30'd0, m0}, 32'd1);
        cyc(1);
        chk("flip_e7_ab", {28'd0, a0, b0}, 32'd0);
        chk("flip_e7_m", {30'd0, m0}, 32'd0);

        // clear after 10 steps freezes outputs
        do_reset();
        delta_i = pack(9'sd100, 9'sd0); delta_stb = 1'b1;
        cyc(1);
        delta_stb = 1'b0;
        cyc(9);
        chk("clr_e10_ab", {28'd0, a0, b0}, {28'd0, 2'b01, 2'b01});
        cyc(1);
        chk("clr_e11_b", {30'd0, b0}, 32'd0);
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        chk("clr_e12_ab", {28'd0, a0, b0}, {28'd0, 2'b01, 2'b00});
        chk("clr_e12_m", {30'd0, m0}, 32'd0);
        cyc(3);
        chk("clr_e15_ab", {28'd0, a0, b0}, {28'd0, 2'b01, 2'b00});

        // reset mid-motion, asserted together with clr and a strobe
        do_reset();
        delta_i = pack(9'sd50, 9'sd0); delta_stb = 1'b1;
        cyc(1);
        delta_stb = 1'b0;
        cyc(3);
        chk("rmm_e4_ab", {28'd0, a0, b0}, {28'd0, 2'b01, 2'b01});
        reset = 1'b1; clr_i = 1'b1; delta_stb = 1'b1; delta_i = pack(9'sd7, 9'sd7);
        cyc(1);
        reset = 1'b0; clr_i = 1'b0; delta_stb = 1'b0; delta_i = '0;
        chk("rmm_rel_0", {26'd0, a0, b0, m0}, 32'd0);
        chk("rmm_rel_1", {26'd0, a1, b1, m1}, 32'd0);
        cyc(5);
        chk("rmm_after_0", {26'd0, a0, b0, m0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
